// File: rtl/uart_rx_oversample.sv
// UART receiver: 2-flop synchroniser, majority-voted mid-bit sampling, optional parity, 1-2 stop bits.
// A word is presented one cycle after the last stop-bit vote; a full, unaccepted holding register drops it and flags overrun.
module uart_rx_oversample #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int CW = $clog2(CLKS_PER_BIT + 1);
    localparam int IW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_HM1  = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] CNT_H    = CW'(CLKS_PER_BIT / 2);
    localparam logic [CW-1:0] CNT_HP1  = CW'(CLKS_PER_BIT / 2 + 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        S_HUNT,
        S_IDLE,
        S_START,
        S_DATA,
        S_PRITY,
        S_STOP
    } state_t;

    state_t                 state_q;
    logic                   sync1_q;
    logic                   rxs_q;
    logic [CW-1:0]          cnt_q;
    logic [IW-1:0]          idx_q;
    logic                   sidx_q;
    logic                   samp_a_q;
    logic                   samp_b_q;
    logic [DATA_BITS-1:0]   shreg_q;
    logic                   pbit_q;
    logic                   ferr_q;
    logic                   done_q;
    logic                   busy_q;

    logic [DATA_BITS-1:0]   rx_data_q, rx_data_d;
    logic                   rx_valid_q, rx_valid_d;
    logic                   perr_out_q, perr_out_d;
    logic                   ferr_out_q, ferr_out_d;
    logic                   overrun_q, overrun_d;

    logic                   vote_bit;
    logic                   at_vote;
    logic                   at_last;
    logic                   stop_last;
    logic                   ferr_d;
    logic                   perr;
    logic [CW-1:0]          cnt_next;

    // Third sample is the live synchronised value, so the vote resolves at H+1.
    assign vote_bit  = (samp_a_q & samp_b_q) | (samp_a_q & rxs_q) | (samp_b_q & rxs_q);
    assign at_vote   = (cnt_q == CNT_HP1);
    assign at_last   = (cnt_q == CNT_LAST);
    assign stop_last = (sidx_q == 1'(STOP_BITS - 1));
    assign ferr_d    = ferr_q | ~vote_bit;
    assign cnt_next  = at_last ? '0 : cnt_q + 1'b1;

    always_comb begin
        perr = 1'b0;
        if (PARITY == 1) begin
            perr = ^{shreg_q, pbit_q};
        end else if (PARITY == 2) begin
            perr = ~^{shreg_q, pbit_q};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q  <= 1'b1;
            rxs_q    <= 1'b1;
            state_q  <= S_HUNT;
            cnt_q    <= '0;
            idx_q    <= '0;
            sidx_q   <= 1'b0;
            samp_a_q <= 1'b0;
            samp_b_q <= 1'b0;
            shreg_q  <= '0;
            pbit_q   <= 1'b0;
            ferr_q   <= 1'b0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            sync1_q <= rx;
            rxs_q   <= sync1_q;
            done_q  <= 1'b0;
            if (cnt_q == CNT_HM1) begin
                samp_a_q <= rxs_q;
            end
            if (cnt_q == CNT_H) begin
                samp_b_q <= rxs_q;
            end
            case (state_q)
                // Needs a full bit time of idle so a reset mid-frame cannot lock onto a data bit.
                S_HUNT: begin
                    if (!rxs_q) begin
                        cnt_q <= '0;
                    end else if (at_last) begin
                        cnt_q   <= '0;
                        state_q <= S_IDLE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_IDLE: begin
                    cnt_q <= '0;
                    if (!rxs_q) begin
                        state_q <= S_START;
                        busy_q  <= 1'b1;
                        ferr_q  <= 1'b0;
                        idx_q   <= '0;
                        sidx_q  <= 1'b0;
                    end
                end
                S_START: begin
                    cnt_q <= cnt_next;
                    if (at_vote && vote_bit) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                        cnt_q   <= '0;
                    end else if (at_last) begin
                        state_q <= S_DATA;
                    end
                end
                S_DATA: begin
                    cnt_q <= cnt_next;
                    if (at_vote) begin
                        shreg_q[idx_q] <= vote_bit;
                    end
                    if (at_last) begin
                        if (idx_q == IDX_LAST) begin
                            idx_q   <= '0;
                            state_q <= (PARITY != 0) ? S_PRITY : S_STOP;
                        end else begin
                            idx_q <= idx_q + 1'b1;
                        end
                    end
                end
                S_PRITY: begin
                    cnt_q <= cnt_next;
                    if (at_vote) begin
                        pbit_q <= vote_bit;
                    end
                    if (at_last) begin
                        state_q <= S_STOP;
                    end
                end
                S_STOP: begin
                    cnt_q <= cnt_next;
                    if (at_vote) begin
                        ferr_q <= ferr_d;
                        if (stop_last) begin
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                            cnt_q   <= '0;
                            state_q <= ferr_d ? S_HUNT : S_IDLE;
                        end
                    end else if (at_last) begin
                        sidx_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= S_HUNT;
                    cnt_q   <= '0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        rx_data_d  = rx_data_q;
        rx_valid_d = rx_valid_q;
        perr_out_d = perr_out_q;
        ferr_out_d = ferr_out_q;
        overrun_d  = 1'b0;
        if (done_q) begin
            if (!rx_valid_q || rx_ready) begin
                rx_data_d  = shreg_q;
                perr_out_d = perr;
                ferr_out_d = ferr_q;
                rx_valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (rx_valid_q && rx_ready) begin
            rx_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            perr_out_q <= 1'b0;
            ferr_out_q <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            perr_out_q <= perr_out_d;
            ferr_out_q <= ferr_out_d;
            overrun_q  <= overrun_d;
        end
    end

    assign rx_data    = rx_data_q;
    assign rx_valid   = rx_valid_q;
    assign parity_err = perr_out_q;
    assign frame_err  = ferr_out_q;
    assign overrun    = overrun_q;
    assign busy       = busy_q;

endmodule
